// File: rtl/sm_pipe_pkg.sv
// sm_pipe_pkg: shared definitions for the elastic pipeline register.
//   stage_state_t   - per-stage occupancy state (EMPTY / HALF / FULL)
//   level_width()   - width of the occupancy count for a given stage count
//   state_occupancy - number of beats held by a stage in a given state
package sm_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_t;

  // Each stage holds up to two beats, so the count spans 0..2*stages.
  function automatic int level_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  function automatic logic [1:0] state_occupancy(input stage_state_t st);
    case (st)
      ST_HALF: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sm_pipe_skid_stage.sv
// sm_pipe_skid_stage: one elastic stage with a main and a skid register.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - clears the held beats on the next edge (data kept)
//   in_valid/in_ready/in_data    - upstream handshake; in_ready is a flop
//   out_valid/out_ready/out_data - downstream handshake from the main register
//   occ_d           - beats held after the next edge (0..2)
//
// state    | meaning
// ST_EMPTY | main and skid empty
// ST_HALF  | main holds a beat, skid empty
// ST_FULL  | main and skid both hold beats; upstream stalled
module sm_pipe_skid_stage
  import sm_pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ_d
);

  stage_state_t     state_q, state_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             accept, drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      m_data_q <= RESET_DATA;
      s_data_q <= RESET_DATA;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Flush wins over any transfer and suppresses data loads as well.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d  = ST_HALF;
            m_data_d = in_data;
          end
        end
        ST_HALF: begin
          if (accept && drain) begin
            m_data_d = in_data;
          end else if (accept) begin
            state_d  = ST_FULL;
            s_data_d = in_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d  = ST_HALF;
            m_data_d = s_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Ready decodes only the state flop, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    out_data  = m_data_q;
  end

  assign occ_d = state_occupancy(state_d);

endmodule

// File: rtl/sm_pipe_reg.sv
// sm_pipe_reg: elastic valid/ready pipeline register of STAGES skid stages.
// Parameters: WIDTH (data bits), STAGES (1..8), RESET_DATA (data reset value).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - synchronous clear of every held beat
//   in_valid/in_ready/in_data    - upstream handshake
//   out_valid/out_ready/out_data - downstream handshake
//   level           - registered count of beats held
module sm_pipe_reg
  import sm_pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               STAGES     = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [level_width(STAGES)-1:0]   level
);

  localparam int LVL_W = level_width(STAGES);

  // Chain links: index k is the input side of stage k, index STAGES the output.
  logic [STAGES:0]            vld;
  logic [STAGES:0]            rdy;
  logic [STAGES:0][WIDTH-1:0] dat;
  logic [STAGES-1:0][1:0]     occ_d;
  logic [LVL_W-1:0]           level_d, level_q;

  assign vld[0]      = in_valid;
  assign dat[0]      = in_data;
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sm_pipe_skid_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_data   (dat[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_data  (dat[k+1]),
      .occ_d     (occ_d[k])
    );
  end

  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = vld[STAGES];
  assign out_data  = dat[STAGES];

  // Summing next-state occupancy keeps level in step with the valid flops.
  always_comb begin
    level_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      level_d = level_d + LVL_W'(occ_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  assign level = level_q;

endmodule

// File: tb/tb_sm_pipe_reg.sv
module tb_sm_pipe_reg;

  localparam int NI = 3;  // instance i has STAGES = i+1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NI-1:0]   flush_v, in_valid_v, in_ready_v, out_valid_v, out_ready_v;
  logic [31:0]     in_data_v  [NI];
  logic [31:0]     out_data_v [NI];
  logic [3:0]      level_v    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(2*(g+1)+1)-1:0] lvl;
    sm_pipe_reg #(
      .WIDTH      (32),
      .STAGES     (g + 1),
      .RESET_DATA (32'h5EED_0000 + 32'(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_v[g]),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_data  (out_data_v[g]),
      .level     (lvl)
    );
    assign level_v[g] = 4'(lvl);
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] mq [NI][$];   // beats held, oldest first
  int          stall [NI];
  bit [NI-1:0] acc_last;
  bit          chk_en = 1'b0;
  int          seq [NI];
  logic [31:0] got [$];

  function automatic logic [31:0] rst_data(input int i);
    return 32'h5EED_0000 + 32'(i);
  endfunction

  task automatic chk(input bit ok, input string nm, input int inst,
                     input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s [stages=%0d] got %0h expected %0h at %0t",
                  nm, inst + 1, act, exp, $time);
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    logic [NI-1:0] ir0, ir1;
    #1;
    ir0 = in_ready_v;
    out_ready_v = ~out_ready_v;
    #1;
    ir1 = in_ready_v;
    out_ready_v = ~out_ready_v;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int sz;
      sz = mq[i].size();
      if (chk_en) begin
        chk(ir0[i] == ir1[i], "comb_ready", i, 64'(ir1[i]), 64'(ir0[i]));
        chk(int'(level_v[i]) == sz, "level", i, 64'(level_v[i]), 64'(sz));
        if (sz == 0)
          chk(out_valid_v[i] == 1'b0, "spurious_valid", i, 64'(out_valid_v[i]), 64'(0));
        else if (out_valid_v[i])
          chk(out_data_v[i] == mq[i][0], "order", i, 64'(out_data_v[i]), 64'(mq[i][0]));
        if (sz > 0 && !out_valid_v[i]) stall[i]++;
        else stall[i] = 0;
        chk(stall[i] <= 2 * (i + 1) + 1, "stall", i, 64'(stall[i]), 64'(2 * (i + 1) + 1));
        if (rst)
          chk(in_ready_v[i] == 1'b0, "rst_ready", i, 64'(in_ready_v[i]), 64'(0));
        else if (sz == 0)
          chk(in_ready_v[i] == 1'b1, "empty_ready", i, 64'(in_ready_v[i]), 64'(1));
        else if (sz == 2 * (i + 1))
          chk(in_ready_v[i] == 1'b0, "full_ready", i, 64'(in_ready_v[i]), 64'(0));
      end
      acc_last[i] = in_valid_v[i] & in_ready_v[i];
      if (rst || flush_v[i]) begin
        mq[i].delete();
      end else begin
        if (out_valid_v[i] && out_ready_v[i]) void'(mq[i].pop_front());
        if (acc_last[i]) mq[i].push_back(in_data_v[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid_v = '0;
    flush_v = '0;
    out_ready_v = '0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int n_acc, a4_after, vbias, rbias;
    bit acc;
    bit ov_a [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int lv_a [5] = '{1, 2, 2, 1, 0};

    rst = 1'b1;
    flush_v = '0;
    in_valid_v = '0;
    out_ready_v = '0;
    for (int i = 0; i < NI; i++) begin
      in_data_v[i] = '0;
      stall[i] = 0;
      seq[i] = 0;
    end
    acc_last = '0;
    @(posedge clk);
    #1;
    do_reset();

    // reset state
    for (int i = 0; i < NI; i++) begin
      chk(out_valid_v[i] == 1'b0, "rst_out_valid", i, 64'(out_valid_v[i]), 64'(0));
      chk(level_v[i] == 4'd0, "rst_level", i, 64'(level_v[i]), 64'(0));
      chk(in_ready_v[i] == 1'b1, "rst_in_ready", i, 64'(in_ready_v[i]), 64'(1));
      chk(out_data_v[i] == rst_data(i), "rst_out_data", i, 64'(out_data_v[i]), 64'(rst_data(i)));
    end

    // stream 1,2,3 through STAGES=2 with out_ready held high
    out_ready_v[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid_v[1] = (k <= 3);
      in_data_v[1] = 32'(k);
      chk(in_ready_v[1] == 1'b1, "strm_in_ready", 1, 64'(in_ready_v[1]), 64'(1));
      step();
      chk(out_valid_v[1] == ov_a[k-1], "strm_out_valid", 1, 64'(out_valid_v[1]), 64'(ov_a[k-1]));
      if (ov_a[k-1])
        chk(out_data_v[1] == 32'(k - 1), "strm_out_data", 1, 64'(out_data_v[1]), 64'(k - 1));
      chk(int'(level_v[1]) == lv_a[k-1], "strm_level", 1, 64'(level_v[1]), 64'(lv_a[k-1]));
    end

    // backpressure fill of STAGES=2 with 0xA0..0xA4
    do_reset();
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid_v[1] = 1'b1;
      in_data_v[1] = 32'hA0 + 32'(n_acc);
      acc = in_ready_v[1];
      step();
      if (acc) n_acc++;
    end
    chk(n_acc == 4, "bp_accepted", 1, 64'(n_acc), 64'(4));
    chk(level_v[1] == 4'd4, "bp_level", 1, 64'(level_v[1]), 64'(4));
    chk(in_ready_v[1] == 1'b0, "bp_in_ready", 1, 64'(in_ready_v[1]), 64'(0));
    out_ready_v[1] = 1'b1;
    got.delete();
    a4_after = -1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid_v[1]) got.push_back(out_data_v[1]);
      acc = 1'b0;
      if (n_acc < 5) begin
        in_valid_v[1] = 1'b1;
        in_data_v[1] = 32'hA0 + 32'(n_acc);
        acc = in_ready_v[1];
        if (acc) a4_after = got.size();
      end else begin
        in_valid_v[1] = 1'b0;
      end
      step();
      if (acc) n_acc++;
    end
    chk(n_acc == 5, "bp_a4_accepted", 1, 64'(n_acc), 64'(5));
    chk(a4_after >= 1, "bp_a4_after_drain", 1, 64'(a4_after), 64'(1));
    chk(got.size() == 5, "bp_count", 1, 64'(got.size()), 64'(5));
    for (int j = 0; j < 5; j++)
      if (j < got.size())
        chk(got[j] == 32'hA0 + 32'(j), "bp_data", 1, 64'(got[j]), 64'(32'hA0 + 32'(j)));
    out_ready_v[1] = 1'b0;

    // STAGES=1 accept+drain every cycle: never uses the skid
    do_reset();
    out_ready_v[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid_v[0] = 1'b1;
      in_data_v[0] = 32'hC0 + 32'(k);
      chk(in_ready_v[0] == 1'b1, "half_in_ready", 0, 64'(in_ready_v[0]), 64'(1));
      step();
      chk(level_v[0] == 4'd1, "half_level", 0, 64'(level_v[0]), 64'(1));
      chk(out_data_v[0] == 32'hC0 + 32'(k), "half_out_data", 0, 64'(out_data_v[0]), 64'(32'hC0 + 32'(k)));
    end
    in_valid_v[0] = 1'b0;
    step();
    chk(level_v[0] == 4'd0, "half_drain_level", 0, 64'(level_v[0]), 64'(0));

    // flush while FULL with 0x77 offered
    do_reset();
    in_valid_v[0] = 1'b1;
    in_data_v[0] = 32'h55;
    step();
    in_data_v[0] = 32'h66;
    step();
    chk(level_v[0] == 4'd2, "full_level", 0, 64'(level_v[0]), 64'(2));
    chk(in_ready_v[0] == 1'b0, "full_in_ready", 0, 64'(in_ready_v[0]), 64'(0));
    chk(out_data_v[0] == 32'h55, "full_out_data", 0, 64'(out_data_v[0]), 64'(32'h55));
    in_data_v[0] = 32'h77;
    flush_v[0] = 1'b1;
    step();
    flush_v[0] = 1'b0;
    in_valid_v[0] = 1'b0;
    chk(out_valid_v[0] == 1'b0, "flush_out_valid", 0, 64'(out_valid_v[0]), 64'(0));
    chk(level_v[0] == 4'd0, "flush_level", 0, 64'(level_v[0]), 64'(0));
    chk(in_ready_v[0] == 1'b1, "flush_in_ready", 0, 64'(in_ready_v[0]), 64'(1));
    out_ready_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk(out_valid_v[0] == 1'b0, "flush_no_77", 0, 64'(out_valid_v[0]), 64'(0));
    end
    // beat accepted in the flush cycle is dropped
    in_valid_v[0] = 1'b1;
    in_data_v[0] = 32'h88;
    out_ready_v[0] = 1'b0;
    step();
    in_data_v[0] = 32'h99;
    flush_v[0] = 1'b1;
    chk(in_ready_v[0] == 1'b1, "flushacc_in_ready", 0, 64'(in_ready_v[0]), 64'(1));
    step();
    flush_v[0] = 1'b0;
    in_valid_v[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk(out_valid_v[0] == 1'b0, "flushacc_out_valid", 0, 64'(out_valid_v[0]), 64'(0));
      chk(level_v[0] == 4'd0, "flushacc_level", 0, 64'(level_v[0]), 64'(0));
      step();
    end

    // one-cycle reset with three beats held in STAGES=3
    do_reset();
    n_acc = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[2] = 1'b1;
      in_data_v[2] = 32'hE0 + 32'(n_acc);
      acc = in_ready_v[2];
      step();
      if (acc) n_acc++;
    end
    in_valid_v[2] = 1'b0;
    chk(level_v[2] == 4'd3, "midrst_level_before", 2, 64'(level_v[2]), 64'(3));
    rst = 1'b1;
    step();
    chk(in_ready_v[2] == 1'b0, "midrst_in_ready", 2, 64'(in_ready_v[2]), 64'(0));
    chk(out_valid_v[2] == 1'b0, "midrst_out_valid", 2, 64'(out_valid_v[2]), 64'(0));
    chk(level_v[2] == 4'd0, "midrst_level", 2, 64'(level_v[2]), 64'(0));
    rst = 1'b0;
    step();
    chk(in_ready_v[2] == 1'b1, "postrst_in_ready", 2, 64'(in_ready_v[2]), 64'(1));
    chk(out_data_v[2] == rst_data(2), "postrst_out_data", 2, 64'(out_data_v[2]), 64'(rst_data(2)));

    // randomized valid/ready with rare flush and reset
    vbias = 50;
    rbias = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        vbias = 25 * (1 + int'($urandom_range(0, 3)));
        rbias = 25 * (1 + int'($urandom_range(0, 3)));
      end
      rst = ($urandom_range(0, 2999) == 0);
      for (int i = 0; i < NI; i++) begin
        flush_v[i] = ($urandom_range(0, 79) == 0);
        out_ready_v[i] = (int'($urandom_range(0, 99)) < rbias);
        if (!(in_valid_v[i] && !acc_last[i])) begin
          in_valid_v[i] = (int'($urandom_range(0, 99)) < vbias);
          seq[i]++;
          in_data_v[i] = {8'(i), 24'(seq[i])};
        end
      end
      step();
    end
    rst = 1'b0;
    flush_v = '0;
    in_valid_v = '0;
    out_ready_v = '1;
    for (int k = 0; k < 10; k++) step();
    for (int i = 0; i < NI; i++)
      chk(level_v[i] == 4'd0, "final_drain", i, 64'(level_v[i]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
